semaforo_ctrl: RTL and testbench

Two-street traffic-light controller that generates the vehicle light codes semA/semB and the pedestrian walk signals A_peatonal/B_peatonal. It is the source side of the semaphore interface: its outputs drive the pedestrian decoder and the bench monitors. Fixed cyclic Moore FSM with per-phase cycle timers and latched pedestrian push-button requests that shorten the opposing green.

---
 rtl/semaforo_pkg.sv | 55 +++++
 rtl/semaforo_timer.sv | 30 +++
 rtl/semaforo_ctrl.sv | 121 ++++++++++++
 tb/tb_semaforo_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types and constants for the two-street traffic-light controller.
package semaforo_pkg;

    localparam int unsigned CNT_W_DEF       = 4;
    localparam int unsigned T_VERDE_DEF     = 8;
    localparam int unsigned T_VERDE_MIN_DEF = 3;
    localparam int unsigned T_AMARILLO_DEF  = 2;
    localparam int unsigned T_ROJO_DEF      = 1;

    // Vehicle light codes; 2'b11 is never driven.
    localparam logic [1:0] ROJO     = 2'b00;
    localparam logic [1:0] AMARILLO = 2'b01;
    localparam logic [1:0] VERDE    = 2'b10;

    typedef enum logic [2:0] {
        ROJO_BA    = 3'd0,
        A_VERDE    = 3'd1,
        A_AMARILLO = 3'd2,
        ROJO_AB    = 3'd3,
        B_VERDE    = 3'd4,
        B_AMARILLO = 3'd5
    } state_t;

    // Full set of lights shown during one phase.
    typedef struct packed {
        logic [1:0] sem_a;
        logic [1:0] sem_b;
        logic       pea_a;
        logic       pea_b;
    } luces_t;

    // Moore output decode: lights shown while in state s.
    function automatic luces_t luces_de(input state_t s);
        luces_t l;
        l.sem_a = ROJO;
        l.sem_b = ROJO;
        l.pea_a = 1'b0;
        l.pea_b = 1'b0;
        case (s)
            A_VERDE: begin
                l.sem_a = VERDE;
                l.pea_b = 1'b1;
            end
            A_AMARILLO: l.sem_a = AMARILLO;
            B_VERDE: begin
                l.sem_b = VERDE;
                l.pea_a = 1'b1;
            end
            B_AMARILLO: l.sem_b = AMARILLO;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Phase timer: counts enabled cycles, restarts at every phase change.
module semaforo_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] cnt,
    output logic             expira_c
);

    // Last cycle of a phase lasting dur enabled cycles.
    assign expira_c = (cnt == (dur - CNT_W'(1)));

    // Counter register, cleared on the edge that leaves the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enb) begin
            if (clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/semaforo_ctrl.sv
// Cyclic two-street traffic-light FSM with latched pedestrian requests.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned T_VERDE     = T_VERDE_DEF,
    parameter int unsigned T_VERDE_MIN = T_VERDE_MIN_DEF,
    parameter int unsigned T_AMARILLO  = T_AMARILLO_DEF,
    parameter int unsigned T_ROJO      = T_ROJO_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       boton_A,
    input  logic       boton_B,
    output logic [1:0] semA,
    output logic [1:0] semB,
    output logic       A_peatonal,
    output logic       B_peatonal
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(T_VERDE_MIN - 1);

    state_t           state;
    state_t           state_nxt;
    logic             req_a;
    logic             req_b;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dur;
    logic             expira_c;
    logic             acorta_c;
    logic             ilegal_c;
    logic             fin_c;
    luces_t           luces_q;

    semaforo_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .clr      (fin_c),
        .dur      (dur),
        .cnt      (cnt),
        .expira_c (expira_c)
    );

    // Phase duration, early-exit on pending request, and successor state.
    always_comb begin
        dur       = CNT_W'(T_ROJO);
        acorta_c  = 1'b0;
        ilegal_c  = 1'b0;
        state_nxt = ROJO_BA;
        case (state)
            ROJO_BA: begin
                dur       = CNT_W'(T_ROJO);
                state_nxt = A_VERDE;
            end
            A_VERDE: begin
                dur       = CNT_W'(T_VERDE);
                acorta_c  = req_a && (cnt >= MIN_CNT);
                state_nxt = A_AMARILLO;
            end
            A_AMARILLO: begin
                dur       = CNT_W'(T_AMARILLO);
                state_nxt = ROJO_AB;
            end
            ROJO_AB: begin
                dur       = CNT_W'(T_ROJO);
                state_nxt = B_VERDE;
            end
            B_VERDE: begin
                dur       = CNT_W'(T_VERDE);
                acorta_c  = req_b && (cnt >= MIN_CNT);
                state_nxt = B_AMARILLO;
            end
            B_AMARILLO: begin
                dur       = CNT_W'(T_AMARILLO);
                state_nxt = ROJO_BA;
            end
            default: begin
                ilegal_c  = 1'b1;
                state_nxt = ROJO_BA;
            end
        endcase
        fin_c = expira_c || acorta_c || ilegal_c;
        if (!fin_c) begin
            state_nxt = state;
        end
    end

    // State, request flags and registered lights; all frozen while enb=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ROJO_BA;
            req_a   <= 1'b0;
            req_b   <= 1'b0;
            luces_q <= '0;
        end else if (enb) begin
            state   <= state_nxt;
            luces_q <= luces_de(state_nxt);
            // A request is served by the walk phase it asked for, so entering it clears the flag.
            if ((state_nxt == B_VERDE) && (state != B_VERDE)) begin
                req_a <= 1'b0;
            end else if (boton_A && (state != B_VERDE)) begin
                req_a <= 1'b1;
            end
            if ((state_nxt == A_VERDE) && (state != A_VERDE)) begin
                req_b <= 1'b0;
            end else if (boton_B && (state != A_VERDE)) begin
                req_b <= 1'b1;
            end
        end
    end

    assign semA       = luces_q.sem_a;
    assign semB       = luces_q.sem_b;
    assign A_peatonal = luces_q.pea_a;
    assign B_peatonal = luces_q.pea_b;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Scoreboard bench for semaforo_ctrl against a phase-table reference model.
module tb_semaforo_ctrl;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       pa;
        logic       pb;
    } exp_t;

    localparam int TVMIN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       boton_A = 1'b0;
    logic       boton_B = 1'b0;
    logic [1:0] semA;
    logic [1:0] semB;
    logic       A_peatonal;
    logic       B_peatonal;

    int n_vec  = 0;
    int n_miss = 0;

    exp_t exp_q[$];

    // Reference model: phase index into a cyclic table, cycles elapsed, request flags.
    int   dur_tab[6] = '{1, 8, 2, 1, 8, 2};
    exp_t out_tab[6] = '{6'b00_00_0_0, 6'b10_00_0_1, 6'b01_00_0_0,
                         6'b00_00_0_0, 6'b00_10_1_0, 6'b00_01_0_0};
    int ph = 0;
    int el = 0;
    bit ra = 1'b0;
    bit rb = 1'b0;

    semaforo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .boton_A    (boton_A),
        .boton_B    (boton_B),
        .semA       (semA),
        .semB       (semB),
        .A_peatonal (A_peatonal),
        .B_peatonal (B_peatonal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        exp_t got;
        got = {semA, semB, A_peatonal, B_peatonal};
        n_vec++;
        if (got !== e) begin
            n_miss++;
            $display("FAIL %s t=%0t got=%b_%b_%b_%b exp=%b_%b_%b_%b", name, $time,
                     got.a, got.b, got.pa, got.pb, e.a, e.b, e.pa, e.pb);
        end
    endtask

    // One enabled edge of the model, applied to the inputs sampled at that edge.
    task automatic model_step(input bit e, input bit a, input bit b);
        bit done;
        bit shorten;
        int nph;
        if (!e) return;
        done    = (el == dur_tab[ph] - 1);
        shorten = ((ph == 1) && ra && (el >= TVMIN - 1)) ||
                  ((ph == 4) && rb && (el >= TVMIN - 1));
        nph = (done || shorten) ? (ph + 1) % 6 : ph;
        if (nph == 4 && ph != 4) ra = 1'b0;
        else if (a && ph != 4)   ra = 1'b1;
        if (nph == 1 && ph != 1) rb = 1'b0;
        else if (b && ph != 1)   rb = 1'b1;
        if (nph != ph) el = 0;
        else           el = el + 1;
        ph = nph;
    endtask

    // Apply inputs for one cycle, predict the result of the edge, return at the next negedge.
    task automatic step(input bit e, input bit a, input bit b);
        enb     = e;
        boton_A = a;
        boton_B = b;
        @(posedge clk);
        model_step(e, a, b);
        exp_q.push_back(out_tab[ph]);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; lights must drop without any clock edge.
    task automatic apply_reset();
        @(negedge clk);
        enb     = 1'b0;
        boton_A = 1'b0;
        boton_B = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_reset", 6'b00_00_0_0);
        exp_q.delete();
        ph = 0;
        el = 0;
        ra = 1'b0;
        rb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", 6'b00_00_0_0);
    endtask

    // Free run with fixed expectations at the phase boundaries after reset.
    task automatic freerun_anchored();
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, 1'b0, 1'b0);
            case (k)
                1, 23:  check("free_a_verde", 6'b10_00_0_1);
                9:      check("free_a_amarillo", 6'b01_00_0_0);
                11, 22: check("free_all_red", 6'b00_00_0_0);
                12:     check("free_b_verde", 6'b00_10_1_0);
                20:     check("free_b_amarillo", 6'b00_01_0_0);
                default: ;
            endcase
        end
    endtask

    // Scoreboard monitor: one prediction per clock, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", e);
        end
    end

    initial begin
        bit hit;

        // Nominal cycle.
        apply_reset();
        freerun_anchored();

        // Request A shortens the current A green.
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, (k == 2), 1'b0);
            if (k == 4) check("short_a_amarillo", 6'b01_00_0_0);
            if (k == 7) check("short_b_verde", 6'b00_10_1_0);
        end

        // Request A held through B green is ignored; next A green is full length.
        apply_reset();
        for (int k = 1; k <= 33; k++) begin
            step(1'b1, (k >= 12 && k <= 19), 1'b0);
            if (k == 30) check("ign_a_still_verde", 6'b10_00_0_1);
            if (k == 31) check("ign_a_amarillo", 6'b01_00_0_0);
        end

        // Late B request in the last green cycle.
        apply_reset();
        for (int k = 1; k <= 45; k++) begin
            step(1'b1, 1'b0, (k == 19));
            if (k == 20) check("late_b_amarillo", 6'b00_01_0_0);
            if (k == 31) check("late_next_a_amarillo", 6'b01_00_0_0);
        end

        // Clock enable low for 5 cycles during A green.
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            step(!(k >= 5 && k <= 9), 1'b0, 1'b0);
            if (k == 13) check("enb_a_still_verde", 6'b10_00_0_1);
            if (k == 14) check("enb_a_amarillo", 6'b01_00_0_0);
        end

        // Reset in the middle of B yellow, then the nominal cycle restarts.
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            step(1'b1, 1'b0, 1'b0);
            hit = (ph == 5);
        end
        if (!hit) begin
            n_vec++;
            n_miss++;
            $display("FAIL reach_b_amarillo got=phase%0d exp=phase5", ph);
        end
        apply_reset();
        freerun_anchored();

        // Randomized traffic with sparse enables gaps, buttons and occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) apply_reset();
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
